spi_frame_tx: RTL

//  SPI initiator that serializes one 3-byte frame (command, databyte1, databyte2) onto cs/sck/sdi.
//  It is the transmitting end of the frame format the graphics-card spi receiver decodes.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_frame_tx_if.sv | 35 +++
 rtl/spi_phase_timer.sv | 35 +++
 rtl/spi_frame_tx.sv | 123 ++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI frame transmitter.
//   FRAME_BITS      : bits per frame (command + two data bytes)
//   spi_frame_t     : one frame as sent, command in the most significant byte
//   spi_tx_state_t  : transmitter FSM states
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int FRAME_BITS = 24;

    typedef struct packed {
        logic [7:0] command;
        logic [7:0] databyte1;
        logic [7:0] databyte2;
    } spi_frame_t;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL,
        GAP
    } spi_tx_state_t;

endpackage

// File: rtl/spi_frame_tx_if.sv
// -----------------------------------------------------------------------------
// spi_frame_tx_if
// Frame request handshake plus SPI pins of the frame transmitter.
//   start/command/databyte1/databyte2 : frame request from the user
//   ready/done                        : handshake status back to the user
//   cs/sck/sdi                        : SPI bus toward the receiver
//   state                             : current FSM state, for observation
// Handshake: a frame is accepted on a rising clk edge where start && ready;
// ready is high only while idle, and start while !ready is simply ignored.
// Modports: master = frame requester, slave = transmitter.
// -----------------------------------------------------------------------------
interface spi_frame_tx_if;

    logic                   start;
    logic [7:0]             command;
    logic [7:0]             databyte1;
    logic [7:0]             databyte2;
    logic                   ready;
    logic                   done;
    logic                   cs;
    logic                   sck;
    logic                   sdi;
    spi_pkg::spi_tx_state_t state;

    modport master (
        output start, command, databyte1, databyte2,
        input  ready, done, cs, sck, sdi, state
    );

    modport slave (
        input  start, command, databyte1, databyte2,
        output ready, done, cs, sck, sdi, state
    );

endinterface

// File: rtl/spi_phase_timer.sv
// -----------------------------------------------------------------------------
// spi_phase_timer
// Down-counter that sets the length of every SPI phase to CLK_DIV clk cycles.
//   clk       in  system clock
//   reset     in  asynchronous, active-high reset (counter cleared)
//   reload    in  restart the phase: counter loads CLK_DIV-1
//   phase_end out high while the counter is at 0 (last cycle of the phase)
// -----------------------------------------------------------------------------
module spi_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    output logic phase_end
);

    localparam int W = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LOAD = W'(CLK_DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (reload) begin
            count <= LOAD;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign phase_end = (count == '0);

endmodule

// File: rtl/spi_frame_tx.sv
// -----------------------------------------------------------------------------
// spi_frame_tx
// SPI mode-0 initiator: sends one 24-bit frame {command, databyte1, databyte2}
// MSB first. sdi changes only while sck is low; the receiver samples on the
// sck rising edge. cs is active-high and frames all 24 bits.
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset; abandons any frame in flight
//   bus    slave modport of spi_frame_tx_if (request handshake + SPI pins)
// Phase sequence: LEAD, then 24 x HIGH interleaved with 23 x LOW, TRAIL, GAP;
// every non-idle state lasts exactly CLK_DIV clk cycles.
// -----------------------------------------------------------------------------
module spi_frame_tx import spi_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          reset,
    spi_frame_tx_if.slave bus
);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("spi_frame_tx: CLK_DIV must be >= 2");
    end

    spi_tx_state_t               state;
    spi_frame_t                  frame_in;
    logic [FRAME_BITS-2:0]       shreg;     // bits still to send after the one on sdi
    logic [4:0]                  bit_cnt;
    logic                        cs_q;
    logic                        sck_q;
    logic                        sdi_q;
    logic                        done_q;
    logic                        accept;
    logic                        reload;
    logic                        phase_end;

    assign frame_in = {bus.command, bus.databyte1, bus.databyte2};
    assign accept   = (state == IDLE) && bus.start;
    // The phase counter restarts on every state transition.
    assign reload   = accept || ((state != IDLE) && phase_end);

    spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .reload    (reload),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            cs_q    <= 1'b0;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Bit 23 goes straight to sdi; the rest waits in shreg.
                        shreg   <= frame_in[FRAME_BITS-2:0];
                        sdi_q   <= frame_in.command[7];
                        bit_cnt <= 5'(FRAME_BITS - 1);
                        cs_q    <= 1'b1;
                        sck_q   <= 1'b0;
                        state   <= LEAD;
                    end
                end
                LEAD: begin
                    if (phase_end) begin
                        sck_q <= 1'b1;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        sck_q <= 1'b0;
                        if (bit_cnt != 5'd0) begin
                            sdi_q   <= shreg[FRAME_BITS-2];
                            shreg   <= {shreg[FRAME_BITS-3:0], 1'b0};
                            bit_cnt <= bit_cnt - 5'd1;
                            state   <= LOW;
                        end else begin
                            state <= TRAIL;
                        end
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        sck_q <= 1'b1;
                        state <= HIGH;
                    end
                end
                TRAIL: begin
                    if (phase_end) begin
                        cs_q   <= 1'b0;
                        sdi_q  <= 1'b0;
                        done_q <= 1'b1;
                        state  <= GAP;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cs    = cs_q;
    assign bus.sck   = sck_q;
    assign bus.sdi   = sdi_q;
    assign bus.done  = done_q;
    assign bus.ready = (state == IDLE);
    assign bus.state = state;

endmodule
